// File: rtl/lsu_mem.sv
// Load/store unit: one single-beat req/ready bus transaction per start, byte-lane
// stores, sign/zero-extended loads. Optional misalignment trap via LSU_MISALIGN_TRAP_EN.
`timescale 1ns/1ps
module lsu_mem #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data_out
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    localparam logic                 TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    state_t               r_state, w_state;
    logic                 r_req, w_req, r_we, w_we, r_busy, w_busy;
    logic                 r_done, w_done, r_err, w_err;
    logic [31:0]          r_addr, w_addr, r_wdata, w_wdata, r_ld, w_ld;
    logic [3:0]           r_wstrb, w_wstrb;
    logic [CNT_WIDTH-1:0] r_cnt, w_cnt;
    logic [1:0]           r_b, w_b;
    logic [2:0]           r_f3, w_f3;

    logic                 w_legal, w_trap;
    logic [3:0]           w_lane_strb;
    logic [31:0]          w_lane_data, w_ext;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;

    always_comb begin
        w_legal = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = !is_store;
            default:                w_legal = 1'b0;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_trap = (funct3[1:0] == 2'b01 && addr_in[0]) ||
                    (funct3[1:0] == 2'b10 && addr_in[1:0] != 2'b00);
`else
    assign w_trap = 1'b0;
`endif

    // Without the trap, misaligned low bits simply fall out of the lane selection.
    always_comb begin
        w_lane_strb = 4'b0000;
        w_lane_data = 32'h0;
        if (is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    w_lane_strb = 4'b0001 << addr_in[1:0];
                    w_lane_data = {4{store_data_in[7:0]}};
                end
                2'b01: begin
                    w_lane_strb = addr_in[1] ? 4'b1100 : 4'b0011;
                    w_lane_data = {2{store_data_in[15:0]}};
                end
                default: begin
                    w_lane_strb = 4'b1111;
                    w_lane_data = store_data_in;
                end
            endcase
        end
    end

    assign w_byte = mem_rdata[8*r_b +: 8];
    assign w_half = r_b[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        case (r_f3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_ext = {24'h0, w_byte};
            3'b101:  w_ext = {16'h0, w_half};
            default: w_ext = mem_rdata;
        endcase
    end

    always_comb begin
        w_state = r_state;
        w_req   = r_req;
        w_we    = r_we;
        w_addr  = r_addr;
        w_wstrb = r_wstrb;
        w_wdata = r_wdata;
        w_done  = 1'b0;
        w_err   = 1'b0;
        w_ld    = r_ld;
        w_cnt   = r_cnt;
        w_b     = r_b;
        w_f3    = r_f3;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (!w_legal || w_trap) begin
                        w_state = S_DONE;
                        w_done  = 1'b1;
                        w_err   = 1'b1;
                        w_ld    = 32'h0;
                    end else begin
                        w_state = S_REQ;
                        w_req   = 1'b1;
                        w_we    = is_store;
                        w_addr  = {addr_in[31:2], 2'b00};
                        w_wstrb = w_lane_strb;
                        w_wdata = w_lane_data;
                        w_cnt   = '0;
                        w_b     = addr_in[1:0];
                        w_f3    = funct3;
                    end
                end
            end
            S_REQ: begin
                // Ready on the limit edge still counts as a normal completion.
                if (mem_ready) begin
                    w_state = S_DONE;
                    w_req   = 1'b0;
                    w_done  = 1'b1;
                    if (!r_we) w_ld = w_ext;
                end else if (TO_EN && r_cnt == LIMIT) begin
                    w_state = S_DONE;
                    w_req   = 1'b0;
                    w_done  = 1'b1;
                    w_err   = 1'b1;
                    w_ld    = 32'h0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_DONE:  w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase
        w_busy = (w_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 32'h0;
            r_wstrb <= 4'b0000;
            r_wdata <= 32'h0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_ld    <= 32'h0;
            r_cnt   <= '0;
            r_b     <= 2'b00;
            r_f3    <= 3'b000;
        end else begin
            r_state <= w_state;
            r_req   <= w_req;
            r_we    <= w_we;
            r_addr  <= w_addr;
            r_wstrb <= w_wstrb;
            r_wdata <= w_wdata;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_err   <= w_err;
            r_ld    <= w_ld;
            r_cnt   <= w_cnt;
            r_b     <= w_b;
            r_f3    <= w_f3;
        end
    end

    assign mem_req       = r_req;
    assign mem_we        = r_we;
    assign mem_addr      = r_addr;
    assign mem_wstrb     = r_wstrb;
    assign mem_wdata     = r_wdata;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;
    assign load_data_out = r_ld;
endmodule

// File: tb/tb_lsu_mem.sv
// Randomized bench for lsu_mem: a transaction-level model predicts bus lanes,
// request length, err and load result; a negedge monitor compares every cycle.
`timescale 1ns/1ps
module tb_lsu_mem;
    localparam int TO = 6;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr_in = 32'h0, store_data_in = 32'h0, mem_rdata = 32'h0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, busy, done, err;
    logic [31:0] mem_addr, mem_wdata, load_data_out;
    logic [3:0]  mem_wstrb;

    lsu_mem #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .funct3(funct3),
        .addr_in(addr_in), .store_data_in(store_data_in), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .busy(busy), .done(done), .err(err), .load_data_out(load_data_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    endtask

    // Model expectations, written only by the stimulus process
    logic        exp_live = 1'b0, exp_req_ok = 1'b0, exp_we = 1'b0, exp_err = 1'b0, exp_chk_ld = 1'b0;
    logic [31:0] exp_addr = 32'h0, exp_wdata = 32'h0, exp_ld = 32'h0;
    logic [3:0]  exp_wstrb = 4'h0;
    int          exp_reqs = 0, exp_seq = 0;
    int          resp_wait = 0;
    logic [31:0] resp_rdata = 32'h0;
    bit          chk_en = 1'b0;

    // Monitor-owned state
    int          done_seq = 0, req_cnt = 0, cap_reqs = 0;
    logic        prev_rst = 1'b0, prev_done = 1'b0, cap_err = 1'b0, cap_we = 1'b0;
    logic [31:0] cap_addr = 32'h0, cap_wdata = 32'h0, cap_ld = 32'h0;
    logic [3:0]  cap_wstrb = 4'h0;

    // Memory responder: ready arrives after resp_wait REQ cycles without it
    int rcnt = 0;
    always @(posedge clk) begin
        #2;
        if (mem_req) begin
            rcnt++;
            mem_ready = (rcnt > resp_wait);
        end else begin
            rcnt = 0;
            mem_ready = 1'b0;
        end
        mem_rdata = mem_ready ? resp_rdata : $urandom;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (!prev_rst) begin
                check("rst_req", {31'h0, mem_req}, 32'h0);
                check("rst_done", {31'h0, done}, 32'h0);
                check("rst_err", {31'h0, err}, 32'h0);
                check("rst_busy", {31'h0, busy}, 32'h0);
                check("rst_ld", load_data_out, 32'h0);
                check("rst_addr", mem_addr, 32'h0);
                check("rst_wstrb", {28'h0, mem_wstrb}, 32'h0);
                req_cnt = 0;
            end else begin
                check("busy", {31'h0, busy}, {31'h0, mem_req | done});
                if (mem_req) begin
                    if (!(exp_live && exp_req_ok && done_seq != exp_seq)) begin
                        check("unexpected_req", 32'h1, 32'h0);
                    end else begin
                        req_cnt++;
                        check("mem_addr", mem_addr, exp_addr);
                        check("mem_we", {31'h0, mem_we}, {31'h0, exp_we});
                        check("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, exp_wstrb});
                        if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
                        if (req_cnt == 1) begin
                            cap_addr = mem_addr; cap_we = mem_we;
                            cap_wstrb = mem_wstrb; cap_wdata = mem_wdata;
                        end
                    end
                end
                if (done) begin
                    check("done_width", {31'h0, prev_done}, 32'h0);
                    check("req_in_done", {31'h0, mem_req}, 32'h0);
                    if (!(exp_live && done_seq != exp_seq)) begin
                        check("unexpected_done", 32'h1, 32'h0);
                    end else begin
                        check("err", {31'h0, err}, {31'h0, exp_err});
                        check("req_cycles", req_cnt, exp_reqs);
                        if (exp_chk_ld) check("load_data", load_data_out, exp_ld);
                        cap_reqs = req_cnt; cap_err = err; cap_ld = load_data_out;
                        done_seq = exp_seq;
                    end
                    req_cnt = 0;
                end else begin
                    check("err_no_done", {31'h0, err}, 32'h0);
                end
            end
        end
        prev_rst = rst_n;
        prev_done = done;
    end

    // Transaction-level model of one access
    task automatic set_exp(input bit st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input int wn, input logic [31:0] rd);
        bit legal, trap, tmo;
        int sz, off;
        longint unsigned v, m;
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        sz    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off   = int'(a[1:0]) & (4 - sz);
        trap  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        trap  = legal && ((a % sz) != 0);
`endif
        exp_addr  = a & 32'hFFFF_FFFC;
        exp_we    = st;
        exp_wstrb = st ? 4'((15 >> (4 - sz)) << off) : 4'h0;
        exp_wdata = (sz == 1) ? (sd & 32'hFF) * 32'h0101_0101 :
                    (sz == 2) ? (sd & 32'hFFFF) * 32'h0001_0001 : sd;
        if (!legal || trap) begin
            exp_req_ok = 1'b0; exp_reqs = 0; exp_err = 1'b1;
            exp_chk_ld = trap; exp_ld = 32'h0;
        end else begin
            tmo        = (wn >= TO);
            exp_req_ok = 1'b1;
            exp_reqs   = tmo ? TO : wn + 1;
            exp_err    = tmo;
            exp_chk_ld = !st || tmo;
            m = (64'd1 << (8 * sz)) - 1;
            v = (64'(rd) >> (8 * off)) & m;
            if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~m;
            exp_ld = tmo ? 32'h0 : v[31:0];
        end
        exp_seq++;
        exp_live = 1'b1;
    endtask

    task automatic launch(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input int wn, input logic [31:0] rd);
        set_exp(st, f3, a, sd, wn, rd);
        resp_wait = wn; resp_rdata = rd;
        is_store = st; funct3 = f3; addr_in = a; store_data_in = sd; start = 1'b1;
        @(posedge clk); #2;
        // Scramble inputs and maybe pulse start again: must be ignored and not re-latched
        start = 1'($urandom_range(0, 1));
        is_store = 1'($urandom_range(0, 1));
        funct3 = 3'($urandom_range(0, 7));
        addr_in = $urandom; store_data_in = $urandom;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (done_seq != exp_seq && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (done_seq != exp_seq) check("done_timeout", 32'h0, 32'h1);
        @(posedge clk); #2;
    endtask

    task automatic do_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input int wn, input logic [31:0] rd);
        launch(st, f3, a, sd, wn, rd);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #2 chk_en = 1'b1;
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #2;

        // LB sign-extends top byte of word
        do_txn(1'b0, 3'b000, 32'h0000_0103, 32'h0, 0, 32'h80FF_1234);
        check("lb_lit_ld", cap_ld, 32'hFFFF_FF80);
        check("lb_lit_err", {31'h0, cap_err}, 32'h0);
        check("lb_lit_reqs", cap_reqs, 32'd1);

        // SH to upper half
        do_txn(1'b1, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 2, 32'h0);
        check("sh_lit_addr", cap_addr, 32'h0000_0200);
        check("sh_lit_wstrb", {28'h0, cap_wstrb}, 32'hC);
        check("sh_lit_wdata", cap_wdata, 32'hBEEF_BEEF);
        check("sh_lit_we", {31'h0, cap_we}, 32'h1);

        // LHU with five wait cycles
        do_txn(1'b0, 3'b101, 32'h0000_0010, 32'h0, 5, 32'h0000_F00D);
        check("lhu_lit_reqs", cap_reqs, 32'd6);
        check("lhu_lit_ld", cap_ld, 32'h0000_F00D);

        // Ready on the limit edge wins over the timeout
        do_txn(1'b0, 3'b010, 32'h0000_0020, 32'h0, TO - 1, 32'hCAFE_0001);
        check("limit_lit_err", {31'h0, cap_err}, 32'h0);
        check("limit_lit_ld", cap_ld, 32'hCAFE_0001);

        // No ready at all -> abort after TO request cycles
        do_txn(1'b0, 3'b010, 32'h0000_0040, 32'h0, 1000, 32'h0);
        check("tmo_lit_reqs", cap_reqs, TO);
        check("tmo_lit_err", {31'h0, cap_err}, 32'h1);
        check("tmo_lit_ld", cap_ld, 32'h0);

        // Misaligned LW
        do_txn(1'b0, 3'b010, 32'h0000_0006, 32'h0, 1, 32'h1234_5678);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis_lit_reqs", cap_reqs, 32'd0);
        check("mis_lit_err", {31'h0, cap_err}, 32'h1);
`else
        check("mis_lit_addr", cap_addr, 32'h0000_0004);
        check("mis_lit_err", {31'h0, cap_err}, 32'h0);
        check("mis_lit_ld", cap_ld, 32'h1234_5678);
`endif

        // Reset in the middle of a request, then an illegal funct3
        launch(1'b0, 3'b010, 32'h0000_0080, 32'h0, 1000, 32'h0);
        @(posedge clk); #2 rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1; exp_live = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        do_txn(1'b0, 3'b011, 32'h0000_0100, 32'h0, 0, 32'h0);
        check("ill_lit_reqs", cap_reqs, 32'd0);
        check("ill_lit_err", {31'h0, cap_err}, 32'h1);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            bit          st;
            logic [2:0]  f3;
            int          wn;
            st = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) != 0) begin
                if (st) f3 = 3'($urandom_range(0, 2));
                else    f3 = (3'($urandom_range(0, 4)) == 3'd3) ? 3'd5 : 3'($urandom_range(0, 4));
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            wn = ($urandom_range(0, 3) == 0) ? $urandom_range(TO - 1, TO + 3) : $urandom_range(0, 4);
            do_txn(st, f3, $urandom, $urandom, wn, $urandom);
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/lsu_mem.md
Name: lsu_mem

Overview:
- Load/store unit directly downstream of the ULA in the EX->MEM path.
- Takes the effective address produced by the ULA (rs1 + imm via ULA_ADD), plus store data and funct3.
- Runs one single-beat transaction on a simple req/ready data-memory bus, drives byte-lane strobes, and returns the load result sign/zero-extended for writeback.
- Multi-cycle: `busy` stalls the pipeline until the `done` pulse.

Parameters:
- TIMEOUT_CYCLES, 16, cycles in REQ without mem_ready before abort; 0 disables timeout.
- CNT_WIDTH, 8, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  launch transaction; sampled only in IDLE
- is_store  input  1  1=store, 0=load
- funct3  input  3  RISC-V width/sign code
- addr_in  input  32  effective address from ULA data_out
- store_data_in  input  32  rs2 value
- mem_req  output  1  bus request
- mem_we  output  1  write enable
- mem_addr  output  32  word address, {addr_in[31:2],2'b00}
- mem_wstrb  output  4  byte-lane enables
- mem_wdata  output  32  lane-replicated store data
- mem_rdata  input  32  read data, valid when mem_ready=1
- mem_ready  input  1  bus completion
- busy  output  1  high in REQ and DONE
- done  output  1  one-cycle completion pulse
- err  output  1  one-cycle pulse, coincident with done, on abort
- load_data_out  output  32  extended load result, held until next accepted start

Behaviour:
- All outputs registered. Reset (rst_n=0 at a clk edge): state=IDLE, all outputs 0, counter 0.
- Reset mid-transaction: mem_req drops at that edge; no done/err is generated.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - start=1 with legal funct3 -> REQ. mem_req=1; mem_addr, mem_we, mem_wstrb and mem_wdata are latched.
  - start=1 with illegal funct3 -> DONE with err=1 and no bus request.
  - Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. Everything else is illegal.
- REQ:
  - Hold mem_req and all bus outputs stable until mem_ready=1 is sampled, then -> DONE.
  - On a load, capture the extended mem_rdata into load_data_out at that same edge.
- DONE:
  - done=1 for exactly one cycle, mem_req=0, then -> IDLE.
  - start during REQ/DONE is ignored and not queued.
- Latency: start sampled at edge 0; mem_req high from edge 0; done high in the cycle after the mem_ready edge. Minimum start->done is 2 cycles (ready on the first REQ cycle).
- Store lanes, with b=addr_in[1:0]:
  - SB: wstrb=4'b0001<<b; wdata={4{store_data_in[7:0]}}.
  - SH: wstrb=addr_in[1]?4'b1100:4'b0011; wdata={2{store_data_in[15:0]}}.
  - SW: wstrb=4'b1111; wdata=store_data_in.
- Loads: mem_we=0, wstrb=0. The byte/half is selected by addr_in[1:0]/addr_in[1]. LB/LH sign-extend; LBU/LHU zero-extend.
- Timeout (TIMEOUT_CYCLES>0):
  - Counter clears on entry to REQ and increments each REQ cycle without ready.
  - When the count reaches TIMEOUT_CYCLES: mem_req drops -> DONE with err=1; load_data_out=0.
  - mem_ready on the same edge as the limit wins: normal completion.
- Misalignment (SH/LH/LHU with addr_in[0]=1; SW/LW with addr_in[1:0]!=0) is handled per Optional Feature.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned access at start issues no bus request -> DONE with err=1 (load_data_out=0). Store memory is untouched.
- Undefined: the offending low address bits are ignored (halfword uses addr_in[1], word uses lane 0). The access proceeds with err=0.

Test Plan:
- LB at addr 0x103, mem_rdata=0x80FF_1234, ready on first REQ cycle -> load_data_out=0xFFFF_FF80; done 2 cycles after start; err=0.
- SH at addr 0x202, store_data_in=0xDEAD_BEEF -> mem_addr=0x200, wstrb=4'b1100, wdata=0xBEEF_BEEF, mem_we=1.
- LHU at addr 0x10, ready after 5 wait cycles, mem_rdata=0x0000_F00D -> mem_req stable 6 cycles; load_data_out=0x0000_F00D.
- TIMEOUT_CYCLES=4, mem_ready never asserted -> mem_req high exactly 4 cycles; done=err=1 one cycle; load_data_out=0; back to IDLE.
- LW at addr 0x6 -> with LSU_MISALIGN_TRAP_EN: no mem_req, done=err=1. Without it: mem_addr=0x4, err=0.
- rst_n low while in REQ, then funct3=3'b011 start -> mem_req=0 next edge, no done. Then the illegal funct3 gives err pulse and no bus request.
